// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// strobe width and the address range check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int WSTRB_W = 4;

    // Widened to 64 bits so base + 4*depth cannot wrap at the top of the map.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] depth);
        return (addr >= base) && ((addr - base) < (depth << 2));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory bus. Handshake: a request is taken on a rising edge where
// data_valid & data_ready; the answer is a single-cycle data_rvalid pulse that
// carries data_rdata and data_err. The requester must hold a request until it
// is taken. dbg_state mirrors the responder FSM for observation.
interface dmem_responder_if #(
    parameter int XLEN = 32
) ();
    import dmem_pkg::*;

    logic               data_valid;
    logic               data_wen;
    logic [XLEN-1:0]    data_addr;
    logic [WSTRB_W-1:0] data_wstrb;
    logic [XLEN-1:0]    data_wdata;
    logic               data_ready;
    logic               data_rvalid;
    logic [XLEN-1:0]    data_rdata;
    logic               data_err;
    dmem_state_e        dbg_state;

    modport master (
        output data_valid, data_wen, data_addr, data_wstrb, data_wdata,
        input  data_ready, data_rvalid, data_rdata, data_err, dbg_state
    );

    modport slave (
        input  data_valid, data_wen, data_addr, data_wstrb, data_wdata,
        output data_ready, data_rvalid, data_rdata, data_err, dbg_state
    );

endinterface

// File: rtl/dmem_responder_sram_array.sv
// Single-port synchronous word array with per-byte write strobes. Read data is
// registered and only changes on an enabled read.
module dmem_sram_array
    import dmem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               en,
    input  logic               wen,
    input  logic [WSTRB_W-1:0] wstrb,
    input  logic [AW-1:0]      idx,
    input  logic [XLEN-1:0]    wdata,
    output logic [XLEN-1:0]    rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                for (int i = 0; i < WSTRB_W; i++) begin
                    if (wstrb[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits WAIT_CYCLES, then
// performs the array access on the edge entering RESP and pulses data_rvalid.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter int              WAIT_CYCLES = 1,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  slv
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_e        state_q;
    logic [3:0]         cnt_q;
    logic [XLEN-1:0]    addr_q;
    logic               wen_q;
    logic [WSTRB_W-1:0] wstrb_q;
    logic [XLEN-1:0]    wdata_q;
    logic               rvalid_q;
    logic               err_q;
    logic               zero_rd_q;

    logic               accept;
    logic               enter_resp;
    logic               hit;
    logic [XLEN-1:0]    cur_addr;
    logic               cur_wen;
    logic [WSTRB_W-1:0] cur_wstrb;
    logic [XLEN-1:0]    cur_wdata;
    logic [XLEN-1:0]    offset;
    logic [AW-1:0]      idx;
    logic [XLEN-1:0]    sram_rdata;
    logic               unused_offset_bits;

    assign slv.data_ready = (state_q == IDLE) & ~rst;
    assign accept         = slv.data_valid & slv.data_ready;

    // With zero wait states the access happens on the accept edge itself, so
    // the live request fields feed the array while IDLE.
    always_comb begin
        cur_addr   = addr_q;
        cur_wen    = wen_q;
        cur_wstrb  = wstrb_q;
        cur_wdata  = wdata_q;
        enter_resp = 1'b0;
        if (state_q == IDLE) begin
            cur_addr   = slv.data_addr;
            cur_wen    = slv.data_wen;
            cur_wstrb  = slv.data_wstrb;
            cur_wdata  = slv.data_wdata;
            enter_resp = accept && (WAIT_CYCLES == 0);
        end else if (state_q == BUSY) begin
            enter_resp = (cnt_q == 4'd0);
        end
    end

    assign hit    = in_range(64'(cur_addr), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    assign offset = cur_addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[1:0], offset[XLEN-1:AW+2]};

    dmem_sram_array #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (enter_resp & hit),
        .wen   (cur_wen),
        .wstrb (cur_wstrb),
        .idx   (idx),
        .wdata (cur_wdata),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            zero_rd_q <= 1'b1;
        end else begin
            rvalid_q <= enter_resp;
            err_q    <= enter_resp & ~hit;
            // An out-of-range read forces zero until the next in-range read.
            if (enter_resp && !cur_wen) begin
                zero_rd_q <= ~hit;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= slv.data_addr;
                        wen_q   <= slv.data_wen;
                        wstrb_q <= slv.data_wstrb;
                        wdata_q <= slv.data_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign slv.data_rvalid = rvalid_q;
    assign slv.data_err    = err_q;
    assign slv.data_rdata  = zero_rd_q ? '0 : sram_rdata;
    assign slv.dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 3 wait
// states driven from one linear sequence of requests.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst    [3];
    logic        valid  [3];
    logic        wen    [3];
    logic [31:0] addr   [3];
    logic [3:0]  wstrb  [3];
    logic [31:0] wdata  [3];
    logic        ready  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];
    logic [1:0]  st     [3];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        dmem_responder_if #(.XLEN(32)) bus ();
        assign bus.data_valid = valid[g];
        assign bus.data_wen   = wen[g];
        assign bus.data_addr  = addr[g];
        assign bus.data_wstrb = wstrb[g];
        assign bus.data_wdata = wdata[g];
        assign ready[g]       = bus.data_ready;
        assign rvalid[g]      = bus.data_rvalid;
        assign rdata[g]       = bus.data_rdata;
        assign err[g]         = bus.data_err;
        assign st[g]          = bus.dbg_state;
        dmem_responder #(
            .XLEN        (32),
            .DEPTH_WORDS (1024),
            .WAIT_CYCLES (W),
            .BASE_ADDR   (32'h8000_0000)
        ) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .slv (bus.slave)
        );
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        int  g;
        bit  got;
        @(negedge clk);
        valid[d] = 1'b1; wen[d] = w; addr[d] = a; wstrb[d] = s; wdata[d] = wd;
        g = 0;
        while (!ready[d] && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("ready_timeout", 32'(ready[d]), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the fields after accept; the response must not see them.
        valid[d] = 1'b0; wen[d] = ~w; addr[d] = a ^ 32'h0000_0ff0;
        wstrb[d] = ~s; wdata[d] = ~wd;
        got = 1'b0; lat = 0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (rvalid[d]) begin
                got = 1'b1; lat = k; rd = rdata[d]; er = err[d];
            end
        end
        check("rvalid_timeout", 32'(got), 32'd1);
        @(negedge clk);
        check("rvalid_one_cycle", 32'(rvalid[d]), 32'd0);
        check("err_without_rvalid", 32'(err[d]), 32'd0);
    endtask

    task automatic xact(input string tag, input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit chk_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        req(d, w, a, s, wd, rd, er, lat);
        check({tag, "_latency"}, 32'(lat), 32'(wait_of(d) + 1));
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
    endtask

    // Hold data_valid high across four writes and measure the ready gap.
    task automatic btb(input int d, input int base_w);
        int lowcnt, rv_at, pulses;
        pulses = 0;
        @(negedge clk);
        valid[d] = 1'b1; wen[d] = 1'b1; wstrb[d] = 4'hF;
        for (int r = 0; r < 4; r++) begin
            addr[d]  = 32'h8000_0000 + 32'((base_w + r) * 4);
            wdata[d] = 32'h5EED_0000 + 32'(d * 256 + r);
            check("btb_ready", 32'(ready[d]), 32'd1);
            @(posedge clk);
            lowcnt = 0; rv_at = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (rvalid[d]) begin
                    pulses++;
                    rv_at = k;
                end
                if (ready[d]) break;
                lowcnt++;
            end
            check("btb_ready_low_cycles", 32'(lowcnt), 32'(wait_of(d) + 1));
            check("btb_rvalid_cycle", 32'(rv_at), 32'(wait_of(d) + 1));
        end
        valid[d] = 1'b0;
        check("btb_pulse_count", 32'(pulses), 32'd4);
        for (int r = 0; r < 4; r++) begin
            xact("btb_readback", d, 1'b0, 32'h8000_0000 + 32'((base_w + r) * 4), 4'h0, 32'h0,
                 32'h5EED_0000 + 32'(d * 256 + r), 1'b1, 1'b0);
        end
    endtask

    initial begin
        int pulses;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; wen[d] = 1'b0; addr[d] = '0;
            wstrb[d] = '0; wdata[d] = '0;
        end
        #2;
        for (int d = 0; d < 3; d++) begin
            check("reset_ready", 32'(ready[d]), 32'd0);
            check("reset_rvalid", 32'(rvalid[d]), 32'd0);
            check("reset_err", 32'(err[d]), 32'd0);
            check("reset_rdata", rdata[d], 32'd0);
            check("reset_state", 32'(st[d]), 32'd0);
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check("ready_after_reset", 32'(ready[d]), 32'd1);

        // Word / byte / half writes with readback on the one-wait-state build.
        xact("sw_word",  1, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
        xact("lw_word",  1, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        xact("sb_lane2", 1, 1'b1, 32'h8000_0010, 4'b0100, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 1'b1, 1'b0);
        xact("lw_sb",    1, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDE5A_BEEF, 1'b1, 1'b0);
        xact("sh_low",   1, 1'b1, 32'h8000_0010, 4'b0011, 32'h1234_1234, 32'hDE5A_BEEF, 1'b1, 1'b0);
        xact("lw_sh",    1, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDE5A_1234, 1'b1, 1'b0);
        xact("sw_nostrb", 1, 1'b1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 32'hDE5A_1234, 1'b1, 1'b0);
        xact("lw_nostrb", 1, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'hDE5A_1234, 1'b1, 1'b0);

        // Range boundaries; the high out-of-range write would alias word 0.
        xact("sw_word0", 1, 1'b1, 32'h8000_0000, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0);
        xact("lw_below", 1, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        xact("sw_above", 1, 1'b1, 32'h8000_1000, 4'hF, 32'h1111_1111, 32'h0, 1'b1, 1'b1);
        xact("lw_word0", 1, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0);
        xact("sw_top",   1, 1'b1, 32'h8000_0FFC, 4'hF, 32'h7777_0FFC, 32'h0BAD_F00D, 1'b1, 1'b0);
        xact("lw_top",   1, 1'b0, 32'h8000_0FFC, 4'h0, 32'h0, 32'h7777_0FFC, 1'b1, 1'b0);

        // Back-to-back throughput on the zero- and three-wait-state builds.
        btb(0, 16);
        btb(2, 32);

        // Reset while a write sits in BUSY on the three-wait-state build.
        xact("sw_w5", 2, 1'b1, 32'h8000_0014, 4'hF, 32'h0102_0305, 32'h0, 1'b0, 1'b0);
        xact("lw_w5", 2, 1'b0, 32'h8000_0014, 4'h0, 32'h0, 32'h0102_0305, 1'b1, 1'b0);
        @(negedge clk);
        valid[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h8000_0014;
        wstrb[2] = 4'hF; wdata[2] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        valid[2] = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(st[2]), 32'd1);
        rst[2] = 1'b1;
        #1;
        check("midreset_ready", 32'(ready[2]), 32'd0);
        check("midreset_rvalid", 32'(rvalid[2]), 32'd0);
        check("midreset_err", 32'(err[2]), 32'd0);
        check("midreset_rdata", rdata[2], 32'd0);
        check("midreset_state", 32'(st[2]), 32'd0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rvalid[2]) pulses++;
        end
        check("midreset_no_rvalid", 32'(pulses), 32'd0);
        rst[2] = 1'b0;
        xact("lw_w5_after_reset", 2, 1'b0, 32'h8000_0014, 4'h0, 32'h0, 32'h0102_0305, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the core's data memory interface. It receives the core's data requests (valid, write enable, byte strobes, write data) and executes them against an internal byte-strobed word array. It returns read data or a write acknowledge after a configurable number of wait states. Used as the core_s data memory in simulation and FPGA builds, with an accept/response handshake that exercises pipeline stalls.

Parameters:
XLEN, 32, data/address width
DEPTH_WORDS, 1024, number of XLEN-bit words in the array (power of 2)
WAIT_CYCLES, 1, wait states between accept and response (0..15)
BASE_ADDR, 32'h8000_0000, byte address of word 0

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
data_valid  input  1  request present
data_wen  input  1  1 = write, 0 = read
data_addr  input  XLEN  byte address; bits [1:0] ignored, lanes selected by data_wstrb
data_wstrb  input  4  byte write strobes; ignored for reads
data_wdata  input  XLEN  write data, already lane-replicated by requester
data_ready  output  1  responder can accept a request this cycle
data_rvalid  output  1  one-cycle response pulse (read data or write ack)
data_rdata  output  XLEN  read data, valid with data_rvalid
data_err  output  1  address out of range, valid with data_rvalid

Behaviour:
- Single clock clk; rst is asynchronous, active-high. All flops reset on rst assertion, independent of clk.
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- data_ready = (state == IDLE) & ~rst. It is combinational from state.
- Accept: a request is accepted when data_valid & data_ready at a rising edge. On accept, latch addr, wen, wstrb and wdata into request registers.
- Transitions after accept:
  - IDLE -> BUSY if WAIT_CYCLES > 0, with the wait counter loaded to WAIT_CYCLES-1.
  - IDLE -> RESP if WAIT_CYCLES == 0.
  - BUSY: the counter decrements each cycle. At count 0 the FSM moves to RESP.
  - RESP always returns to IDLE after one cycle.
- Latency: accept at edge T gives data_rvalid high during cycle T+WAIT_CYCLES+1. Throughput is one request per WAIT_CYCLES+2 cycles.
- Array access occurs on the edge entering RESP:
  - Write: for each i with wstrb[i]=1, byte i of word[idx] <= wdata[8i+7:8i]. wstrb=0 produces no change but is still acknowledged.
  - Read: the registered data_rdata <= word[idx], full word. The requester extracts and extends the bytes.
- Index: idx = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- Range: an address is out of range if addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS. In that case:
  - data_err=1 with data_rvalid.
  - A write is dropped.
  - A read returns data_rdata = 0.
- data_err is 0 whenever data_rvalid = 0.
- data_rdata holds its last value outside RESP. After a write response it is unchanged.
- data_valid while not ready: the request is ignored, with no latching. The requester must hold it until data_ready is high.
- Changes to input request fields after accept have no effect.
- Reset values: data_rvalid=0, data_err=0, data_rdata=0, data_ready=0 while rst is high, state=IDLE, counter=0.
- Reset mid-operation (BUSY or RESP): return to IDLE. A pending write is discarded. A write already committed remains. Array contents are never reset.

Decomposition:
- Shared package (dmem_pkg): typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_e; constant WSTRB_W = 4; range-check function in_range(addr, base, depth).
- Sub-module dmem_sram_array holds the single-port, synchronous, byte-strobed DEPTH_WORDS x XLEN array. Its ports are clk, en, wen, wstrb, idx, wdata and rdata. The responder FSM drives it.

Test Plan:
- Reset then SW addr=0x8000_0010, wstrb=4'hF, wdata=0xDEADBEEF; then LW same addr (WAIT_CYCLES=1) -> each data_rvalid pulse 2 cycles after accept; read data_rdata=0xDEADBEEF, data_err=0.
- SB wstrb=4'b0100, wdata=0x5A5A5A5A to 0x8000_0010, then LW -> data_rdata=0xDE5ABEEF. SH wstrb=4'b0011, wdata=0x12341234, then LW -> 0xDE5A1234.
- LW at 0x7FFF_FFFC, and SW at BASE+4*DEPTH_WORDS with 0x11111111 -> data_err=1 and data_rvalid=1. LW rdata=0. A subsequent read of word 0 is unchanged.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds, back-to-back requests with data_valid held high -> data_ready low for 1 and 4 cycles respectively after each accept; data_rvalid at accept+1 and accept+4; no request lost or duplicated.
- Assert rst during BUSY of SW 0xCAFEF00D to word 5 (WAIT_CYCLES=3) -> outputs return to reset values immediately, no data_rvalid; after reset, LW word 5 returns its old value.
- SW with wstrb=0 -> ack pulse, data_err=0, word unchanged on readback.
